// File: rtl/gpu_cmd_queue_pkg.sv
// Shared types for the GPU command queue: raster opcodes, the queued draw
// command bundle and the dispatch FSM state encoding.
package gpu_cmd_queue_pkg;

    localparam int GPU_COORD_W  = 8;
    localparam int GPU_COLOUR_W = 3;

    typedef enum logic [2:0] {
        RC_NOP,
        RC_PIXEL,
        RC_LINE,
        RC_RECT,
        RC_FILL_RECT,
        RC_CIRCLE,
        RC_CLEAR,
        RC_BLIT
    } raster_command_t;

    typedef struct packed {
        raster_command_t         command;
        logic [GPU_COORD_W-1:0]  x0;
        logic [GPU_COORD_W-1:0]  y0;
        logic [GPU_COORD_W-1:0]  x1;
        logic [GPU_COORD_W-1:0]  y1;
        logic [GPU_COLOUR_W-1:0] colour;
    } gpu_draw_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } gpu_queue_state_t;

endpackage

// File: rtl/gpu_cmd_queue_fifo.sv
// Generic circular-buffer FIFO with registered count/full/empty and flush.
// Ports: clk_i/rst_i, push_i/pop_i/flush_i, wdata_i -> rdata_o (head),
//        full_o, empty_o, empty_next_o (empty after this edge), count_o.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       empty_next_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // flush wins over a same-cycle push; the entry is simply dropped
    assign do_push = push_i && !full_q && !flush_i;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (flush_i) rptr_q <= wptr_q;
            else if (do_pop) rptr_q <= rptr_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == CNT_MAX);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o      = mem_q[rptr_q];
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign empty_next_o = (count_d == '0);
    assign count_o      = count_q;

endmodule

// File: rtl/gpu_cmd_queue.sv
// Command queue between the CPU and the rasteriser: buffers draw commands and
// issues them in order with a one-cycle gpu_execute_request, never while busy.
// Ports: push + *_in enqueue, flush drops queued entries; full/count/overflow/
//        idle status; gpu_* command outputs, gpu_execute_request, gpu_busy in.
module gpu_cmd_queue
    import gpu_cmd_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int COORD_W  = GPU_COORD_W,
    parameter int COLOUR_W = GPU_COLOUR_W
) (
    input  logic                       clk,
    input  logic                       rst_async,
    input  logic                       push,
    input  raster_command_t            cmd_in,
    input  logic [COORD_W-1:0]         x0_in,
    input  logic [COORD_W-1:0]         y0_in,
    input  logic [COORD_W-1:0]         x1_in,
    input  logic [COORD_W-1:0]         y1_in,
    input  logic [COLOUR_W-1:0]        colour_in,
    input  logic                       flush,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       idle,
    output raster_command_t            gpu_command,
    output logic [COORD_W-1:0]         gpu_x0,
    output logic [COORD_W-1:0]         gpu_y0,
    output logic [COORD_W-1:0]         gpu_x1,
    output logic [COORD_W-1:0]         gpu_y1,
    output logic [COLOUR_W-1:0]        gpu_colour,
    output logic                       gpu_execute_request,
    input  logic                       gpu_busy
);
    gpu_queue_state_t state_q;
    gpu_draw_cmd_t    entry_in, head, out_q;
    logic             req_q, overflow_q, idle_q;
    logic             empty, empty_next, issue;

    assign entry_in = '{command: cmd_in, x0: x0_in, y0: y0_in,
                        x1: x1_in, y1: y1_in, colour: colour_in};

    assign issue = (state_q == IDLE) && !empty && !gpu_busy;

    sync_fifo #(
        .WIDTH ($bits(gpu_draw_cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst_async),
        .push_i       (push),
        .pop_i        (issue),
        .flush_i      (flush),
        .wdata_i      (entry_in),
        .rdata_o      (head),
        .full_o       (full),
        .empty_o      (empty),
        .empty_next_o (empty_next),
        .count_o      (count)
    );

    // idle_q is computed from the next FSM state and next queue occupancy
    // so it stays a plain register aligned with count/full.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q    <= IDLE;
            out_q      <= '0;
            req_q      <= 1'b0;
            overflow_q <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            if (flush) overflow_q <= 1'b0;
            else if (push && full) overflow_q <= 1'b1;
            req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= ISSUE;
                        out_q   <= head;
                        req_q   <= 1'b1;
                        idle_q  <= 1'b0;
                    end else begin
                        idle_q <= empty_next;
                    end
                end
                ISSUE: state_q <= WAIT_START;
                WAIT_START: begin
                    // busy never rising means a zero-length command
                    if (gpu_busy) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        state_q <= IDLE;
                        idle_q  <= empty_next;
                    end
                end
                WAIT_DONE: begin
                    if (!gpu_busy) begin
                        state_q <= IDLE;
                        idle_q  <= empty_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign overflow            = overflow_q;
    assign idle                = idle_q;
    assign gpu_command         = out_q.command;
    assign gpu_x0              = out_q.x0;
    assign gpu_y0              = out_q.y0;
    assign gpu_x1              = out_q.x1;
    assign gpu_y1              = out_q.y1;
    assign gpu_colour          = out_q.colour;
    assign gpu_execute_request = req_q;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Directed bench for gpu_cmd_queue with a small rasteriser busy model.
module tb_gpu_cmd_queue;
    import gpu_cmd_queue_pkg::*;

    logic            clk = 1'b0;
    logic            rst_async = 1'b1;
    logic            push = 1'b0;
    raster_command_t cmd_in = RC_NOP;
    logic [7:0]      x0_in = '0, y0_in = '0, x1_in = '0, y1_in = '0;
    logic [2:0]      colour_in = '0;
    logic            flush = 1'b0;
    logic            full, overflow, idle;
    logic [3:0]      count;
    raster_command_t gpu_command;
    logic [7:0]      gpu_x0, gpu_y0, gpu_x1, gpu_y1;
    logic [2:0]      gpu_colour;
    logic            gpu_execute_request;
    logic            gpu_busy = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    int busy_len = 5;
    bit hold_busy = 1'b0;
    int bcnt = 0;
    bit pend = 1'b0;

    gpu_draw_cmd_t issued_q[$];
    int            issued_cyc[$];
    gpu_draw_cmd_t cur;

    gpu_cmd_queue #(.DEPTH(8)) dut (
        .clk                 (clk),
        .rst_async           (rst_async),
        .push                (push),
        .cmd_in              (cmd_in),
        .x0_in               (x0_in),
        .y0_in               (y0_in),
        .x1_in               (x1_in),
        .y1_in               (y1_in),
        .colour_in           (colour_in),
        .flush               (flush),
        .full                (full),
        .count               (count),
        .overflow            (overflow),
        .idle                (idle),
        .gpu_command         (gpu_command),
        .gpu_x0              (gpu_x0),
        .gpu_y0              (gpu_y0),
        .gpu_x1              (gpu_x1),
        .gpu_y1              (gpu_y1),
        .gpu_colour          (gpu_colour),
        .gpu_execute_request (gpu_execute_request),
        .gpu_busy            (gpu_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Rasteriser model: busy rises the cycle after a request and stays
    // high for busy_len cycles; hold_busy forces it high.
    always @(negedge clk) begin
        if (rst_async) begin
            bcnt = 0;
            pend = 1'b0;
        end else begin
            if (bcnt > 0) bcnt = bcnt - 1;
            if (pend) begin
                pend = 1'b0;
                bcnt = busy_len;
            end
            if (gpu_execute_request === 1'b1) begin
                pend = 1'b1;
                cur = '{command: gpu_command, x0: gpu_x0, y0: gpu_y0,
                        x1: gpu_x1, y1: gpu_y1, colour: gpu_colour};
                issued_q.push_back(cur);
                issued_cyc.push_back(cyc);
            end
        end
        gpu_busy = hold_busy || (bcnt > 0);
    end

    function automatic gpu_draw_cmd_t mk(input int k);
        gpu_draw_cmd_t e;
        int c;
        c = k % 8;
        e.command = raster_command_t'(c[2:0]);
        e.x0      = 8'(k * 3);
        e.y0      = 8'(k + 40);
        e.x1      = 8'(255 - k);
        e.y1      = 8'(k * 7);
        e.colour  = 3'(k + 1);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input gpu_draw_cmd_t e);
        push      = 1'b1;
        cmd_in    = e.command;
        x0_in     = e.x0;
        y0_in     = e.y0;
        x1_in     = e.x1;
        y1_in     = e.y1;
        colour_in = e.colour;
        tick();
        push = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle timeout: idle=%b required 1", name, idle);
        end
    endtask

    task automatic test_reset();
        rst_async = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset count: got %0d required 0", count);
        end
        n_checks++;
        if ({full, overflow, gpu_execute_request} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset flags: full/ovf/req=%b required 000",
                     {full, overflow, gpu_execute_request});
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset idle: got %b required 1", idle);
        end
        n_checks++;
        if ({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour} !== '0) begin
            n_fail++;
            $display("FAIL reset gpu outputs: got %h required 0",
                     {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour});
        end
        #2;
        rst_async = 1'b0;
        tick();
    endtask

    task automatic test_single();
        gpu_draw_cmd_t e;
        e = '{command: RC_RECT, x0: 8'd10, y0: 8'd90,
              x1: 8'd204, y1: 8'd130, colour: 3'd6};
        busy_len = 5;
        issued_q.delete();
        issued_cyc.delete();
        do_push(e);
        n_checks++;
        if ({gpu_execute_request, count, idle} !== {1'b0, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL single after push: req/count/idle=%b/%0d/%b required 0/1/0",
                     gpu_execute_request, count, idle);
        end
        tick();
        n_checks++;
        if (gpu_execute_request !== 1'b1) begin
            n_fail++;
            $display("FAIL single request latency: req=%b required 1",
                     gpu_execute_request);
        end
        n_checks++;
        if ({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour} !== e) begin
            n_fail++;
            $display("FAIL single outputs: got %h required %h",
                     {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour}, e);
        end
        tick();
        n_checks++;
        if (gpu_execute_request !== 1'b0) begin
            n_fail++;
            $display("FAIL single pulse width: req=%b required 0",
                     gpu_execute_request);
        end
        wait_idle(40, "single");
        n_checks++;
        if (issued_q.size() != 1) begin
            n_fail++;
            $display("FAIL single request count: got %0d required 1",
                     issued_q.size());
        end
    endtask

    task automatic test_fill_overflow();
        issued_q.delete();
        issued_cyc.delete();
        hold_busy = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < 9; k++) do_push(mk(k));
        n_checks++;
        if ({count, full, overflow} !== {4'd8, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL fill status: count/full/ovf=%0d/%b/%b required 8/1/1",
                     count, full, overflow);
        end
        n_checks++;
        if (issued_q.size() != 0) begin
            n_fail++;
            $display("FAIL fill issued while busy: got %0d required 0",
                     issued_q.size());
        end
        busy_len = 2;
        hold_busy = 1'b0;
        tick();
        wait_idle(300, "fill");
        n_checks++;
        if (issued_q.size() != 8) begin
            n_fail++;
            $display("FAIL fill request count: got %0d required 8",
                     issued_q.size());
        end
        for (int k = 0; k < 8 && k < issued_q.size(); k++) begin
            n_checks++;
            if (issued_q[k] !== mk(k)) begin
                n_fail++;
                $display("FAIL fill order %0d: got %h required %h",
                         k, issued_q[k], mk(k));
            end
        end
    endtask

    task automatic test_wrap();
        issued_q.delete();
        issued_cyc.delete();
        busy_len = 1;
        for (int i = 0; i < 20; i++) begin
            do_push(mk(100 + i));
            repeat ((i % 3) + 2) tick();
        end
        wait_idle(300, "wrap");
        n_checks++;
        if (issued_q.size() != 20) begin
            n_fail++;
            $display("FAIL wrap request count: got %0d required 20",
                     issued_q.size());
        end
        for (int i = 0; i < 20 && i < issued_q.size(); i++) begin
            n_checks++;
            if (issued_q[i] !== mk(100 + i)) begin
                n_fail++;
                $display("FAIL wrap order %0d: got %h required %h",
                         i, issued_q[i], mk(100 + i));
            end
        end
    endtask

    task automatic test_flush_inflight();
        issued_q.delete();
        issued_cyc.delete();
        busy_len = 20;
        for (int i = 0; i < 4; i++) do_push(mk(50 + i));
        n_checks++;
        if (count !== 4'd3) begin
            n_fail++;
            $display("FAIL flush pre count: got %0d required 3", count);
        end
        flush = 1'b1;
        do_push(mk(60));
        flush = 1'b0;
        n_checks++;
        if ({count, full, overflow} !== {4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush status: count/full/ovf=%0d/%b/%b required 0/0/0",
                     count, full, overflow);
        end
        wait_idle(60, "flush");
        repeat (10) tick();
        n_checks++;
        if (issued_q.size() != 1) begin
            n_fail++;
            $display("FAIL flush requests: got %0d required 1",
                     issued_q.size());
        end
    endtask

    task automatic test_zero_length();
        issued_q.delete();
        issued_cyc.delete();
        busy_len = 0;
        do_push(mk(200));
        do_push(mk(201));
        wait_idle(40, "zero");
        n_checks++;
        if (issued_q.size() != 2) begin
            n_fail++;
            $display("FAIL zero request count: got %0d required 2",
                     issued_q.size());
        end else begin
            n_checks++;
            if (issued_cyc[1] - issued_cyc[0] != 3) begin
                n_fail++;
                $display("FAIL zero spacing: got %0d required 3",
                         issued_cyc[1] - issued_cyc[0]);
            end
            n_checks++;
            if (issued_q[1] !== mk(201)) begin
                n_fail++;
                $display("FAIL zero second data: got %h required %h",
                         issued_q[1], mk(201));
            end
        end
    endtask

    task automatic test_reset_mid();
        busy_len = 20;
        for (int i = 0; i < 4; i++) do_push(mk(80 + i));
        issued_q.delete();
        issued_cyc.delete();
        n_checks++;
        if (count !== 4'd3) begin
            n_fail++;
            $display("FAIL rstmid pre count: got %0d required 3", count);
        end
        #2;
        rst_async = 1'b1;
        #1;
        n_checks++;
        if ({count, full, overflow, gpu_execute_request} !== 7'd0) begin
            n_fail++;
            $display("FAIL rstmid status: count/full/ovf/req=%0d/%b/%b/%b required 0",
                     count, full, overflow, gpu_execute_request);
        end
        n_checks++;
        if ({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour} !== '0) begin
            n_fail++;
            $display("FAIL rstmid gpu outputs: got %h required 0",
                     {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour});
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid idle: got %b required 1", idle);
        end
        tick();
        #3;
        rst_async = 1'b0;
        repeat (15) tick();
        n_checks++;
        if (issued_q.size() != 0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid after release: requests=%0d idle=%b required 0/1",
                     issued_q.size(), idle);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_wrap();
        test_flush_inflight();
        test_zero_length();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
